ysyx_22050039_lsu: RTL

Load/store unit sitting directly downstream of the EXU in the ysyx_22050039 RV64 core: accepts one memory operation per handshake, formats byte lanes and write mask, runs a valid/ready transaction on the data memory port, and returns sign/zero-extended load data (or a store ack) to writeback. Replaces the combinational DPI data access in EXU with a multi-cycle, stallable path; one operation outstanding at a time.

---
 rtl/ysyx_22050039_pkg.sv | 10 +
 rtl/ysyx_22050039_lsu_if.sv | 30 +++
 rtl/ysyx_22050039_lsu_align.sv | 27 ++
 rtl/ysyx_22050039_lsu.sv | 92 +++++++++
 4 files changed

// File: rtl/ysyx_22050039_pkg.sv
// ysyx_22050039_pkg: shared width, access-size encodings and LSU state type.
package ysyx_22050039_pkg;
    localparam int XLEN = 64;
    typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11} size_e;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;
    // Natural alignment: an access of 2^size bytes must have its low size address bits clear.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        return (size == SZ_H && off[0]) || (size == SZ_W && |off[1:0]) || (size == SZ_D && |off);
    endfunction
endpackage

// File: rtl/ysyx_22050039_lsu_if.sv
// ysyx_22050039_lsu_if: EXU request, data-memory and writeback channels of the LSU.
interface ysyx_22050039_lsu_if;
    import ysyx_22050039_pkg::*;
    logic            req_valid, req_ready, req_store, req_unsigned;
    logic [1:0]      req_size;
    logic [XLEN-1:0] req_addr, req_wdata;
    logic [4:0]      req_rd;
    logic            mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]      mem_wmask;
    logic            wb_valid, wb_ready, wb_fault;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    modport master (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        output req_ready,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output wb_valid, wb_rd, wb_data, wb_fault,
        input  wb_ready
    );
    modport slave (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  wb_valid, wb_rd, wb_data, wb_fault,
        output wb_ready
    );
endinterface

// File: rtl/ysyx_22050039_lsu_align.sv
// ysyx_22050039_lsu_align: store lane/strobe placement and load byte extract + sign/zero extend.
module ysyx_22050039_lsu_align
    import ysyx_22050039_pkg::*;
(
    input  logic [1:0]      st_size,
    input  logic [2:0]      st_off,
    input  logic [XLEN-1:0] st_data,
    input  logic [1:0]      ld_size,
    input  logic [2:0]      ld_off,
    input  logic            ld_unsigned,
    input  logic [XLEN-1:0] ld_raw,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ldata
);
    logic [7:0]      base;
    logic [XLEN-1:0] sh;
    always_comb begin
        base  = st_size == SZ_B ? 8'h01 : st_size == SZ_H ? 8'h03 : 8'h0F;
        wmask = st_size == SZ_D ? 8'hFF : base << st_off;
        wdata = st_data << {st_off, 3'b000};
        sh    = ld_raw >> {ld_off, 3'b000};
        ldata = ld_size == SZ_B ? {{(XLEN-8){~ld_unsigned & sh[7]}}, sh[7:0]} :
                ld_size == SZ_H ? {{(XLEN-16){~ld_unsigned & sh[15]}}, sh[15:0]} :
                ld_size == SZ_W ? {{(XLEN-32){~ld_unsigned & sh[31]}}, sh[31:0]} : sh;
    end
endmodule

// File: rtl/ysyx_22050039_lsu.sv
// ysyx_22050039_lsu: one-outstanding-op load/store unit between EXU and the data memory port.
// Define YSYX_22050039_LSU_MISALIGN_CHECK_EN to fault misaligned accesses instead of issuing them.
module ysyx_22050039_lsu
    import ysyx_22050039_pkg::*;
(
    input logic clk,
    input logic rst,
    ysyx_22050039_lsu_if.master bus
);
    lsu_state_e      state;
    logic            store_q, uns_q, fault;
    logic [1:0]      size_q;
    logic [2:0]      off_q;
    logic [7:0]      wmask;
    logic [XLEN-1:0] wdata, ldata;

    ysyx_22050039_lsu_align u_align (
        .st_size(bus.req_size), .st_off(bus.req_addr[2:0]), .st_data(bus.req_wdata),
        .ld_size(size_q), .ld_off(off_q), .ld_unsigned(uns_q), .ld_raw(bus.mem_rdata),
        .wmask(wmask), .wdata(wdata), .ldata(ldata)
    );

`ifdef YSYX_22050039_LSU_MISALIGN_CHECK_EN
    assign fault = misaligned(bus.req_size, bus.req_addr[2:0]);
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            store_q           <= 1'b0;
            uns_q             <= 1'b0;
            size_q            <= 2'b00;
            off_q             <= 3'b000;
            bus.req_ready     <= 1'b0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_we        <= 1'b0;
            bus.mem_addr      <= '0;
            bus.mem_wdata     <= '0;
            bus.mem_wmask     <= 8'h00;
            bus.wb_valid      <= 1'b0;
            bus.wb_rd         <= 5'd0;
            bus.wb_data       <= '0;
            bus.wb_fault      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        store_q       <= bus.req_store;
                        uns_q         <= bus.req_unsigned;
                        size_q        <= bus.req_size;
                        off_q         <= bus.req_addr[2:0];
                        bus.wb_rd     <= bus.req_rd;
                        if (fault) begin
                            state        <= RESP;
                            bus.wb_valid <= 1'b1;
                            bus.wb_fault <= 1'b1;
                            bus.wb_data  <= '0;
                        end else begin
                            state             <= REQ;
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_we        <= bus.req_store;
                            bus.mem_addr      <= {bus.req_addr[XLEN-1:3], 3'b000};
                            bus.mem_wdata     <= bus.req_store ? wdata : '0;
                            bus.mem_wmask     <= bus.req_store ? wmask : 8'h00;
                        end
                    end
                end
                REQ: if (bus.mem_req_ready) begin
                    bus.mem_req_valid <= 1'b0;
                    state             <= WAIT;
                end
                WAIT: if (bus.mem_resp_valid) begin
                    bus.wb_valid <= 1'b1;
                    bus.wb_data  <= store_q ? '0 : ldata;
                    state        <= RESP;
                end
                RESP: if (bus.wb_ready) begin
                    bus.wb_valid  <= 1'b0;
                    bus.wb_fault  <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

    a_no_resp_in_req: assert property (@(posedge clk) disable iff (!rst) !(state == REQ && bus.mem_resp_valid));
endmodule
